// File: rtl/mem_bus_arbiter_pkg.sv
// pkg_mem_arb: shared types and constants for the two-master memory bus arbiter.
package pkg_mem_arb;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY_CPU, ST_BUSY_AUX} arb_state_e;
  localparam logic arb_req_cpu = 1'b0;
  localparam logic arb_req_aux = 1'b1;
  localparam int ARB_TIMEOUT_DEFAULT = 255;
  // Access-size encoding shared with the CPU's own bus.
  localparam logic CPU_SZ_8  = 1'b0;
  localparam logic CPU_SZ_16 = 1'b1;
  function automatic arb_state_e busy_state(input logic idx);
    return idx == arb_req_aux ? ST_BUSY_AUX : ST_BUSY_CPU;
  endfunction
endpackage

// File: rtl/mem_bus_arbiter_rr_arbiter_2.sv
// rr_arbiter_2: combinational two-input round-robin pick favouring the requester that did not win last.
module rr_arbiter_2
  import pkg_mem_arb::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       grant_o,
  output logic       valid_o
);
  always_comb begin
    valid_o = |req_i;
    grant_o = &req_i ? ~last_i : (req_i[1] ? arb_req_aux : arb_req_cpu);
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between the CPU and an auxiliary master with a timeout watchdog.
module mem_bus_arbiter
  import pkg_mem_arb::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_sz,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic              aux_sz,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic [DATA_W-1:0] aux_rdata,
  output logic              aux_ready,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_sz,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  arb_state_e      state_q;
  logic            last_q, gnt, gnt_vld, own_aux, abort;
  logic [WD_W-1:0] wd_q, wd_d;
  rr_arbiter_2 u_rr (
    .req_i  ({aux_req, cpu_req}),
    .last_i (last_q),
    .grant_o(gnt),
    .valid_o(gnt_vld)
  );
  assign wd_d    = wd_q + WD_W'(1);
  assign own_aux = state_q == ST_BUSY_AUX;
  // A memory answer on the watchdog's final cycle still counts as a normal completion.
  assign abort   = !mem_ready && wd_d == WD_W'(TIMEOUT);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      last_q    <= arb_req_aux;
      wd_q      <= '0;
      cpu_rdata <= '0;
      cpu_ready <= 1'b0;
      aux_rdata <= '0;
      aux_ready <= 1'b0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_sz    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      cpu_ready <= 1'b0;
      aux_ready <= 1'b0;
      err       <= 1'b0;
      case (state_q)
        ST_IDLE: if (gnt_vld) begin
          state_q   <= busy_state(gnt);
          last_q    <= gnt;
          mem_req   <= 1'b1;
          mem_we    <= gnt ? aux_we : cpu_we;
          mem_sz    <= gnt ? aux_sz : cpu_sz;
          mem_addr  <= gnt ? aux_addr : cpu_addr;
          mem_wdata <= gnt ? aux_wdata : cpu_wdata;
        end
        ST_BUSY_CPU, ST_BUSY_AUX: begin
          if (mem_ready || abort) begin
            state_q   <= ST_IDLE;
            mem_req   <= 1'b0;
            wd_q      <= '0;
            err       <= abort;
            cpu_ready <= !own_aux;
            aux_ready <= own_aux;
            if (abort || !mem_we) begin
              if (own_aux) aux_rdata <= abort ? '0 : mem_rdata;
              else cpu_rdata <= abort ? '0 : mem_rdata;
            end
          end else begin
            wd_q <= wd_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single 16-bit memory port between two requesters: the spark80 CPU (requester 0) and an auxiliary master such as DMA or a debug loader (requester 1).
- Grants one transaction at a time, round-robin, and latches the winner's command.
- Holds the memory-side signals stable until the memory answers, then returns read data and a one-cycle ready to the owner.
- A watchdog aborts transactions the memory never answers.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- TIMEOUT, 255, max cycles waiting for mem_ready before abort; minimum 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU requests a transaction (level; held until cpu_ready)
- cpu_we  in  1  1 = write, 0 = read
- cpu_sz  in  1  access size, 0 = 8-bit, 1 = 16-bit (pkg_cpu encoding)
- cpu_addr  in  ADDR_W  address
- cpu_wdata  in  DATA_W  write data
- cpu_rdata  out  DATA_W  read data, valid while cpu_ready = 1
- cpu_ready  out  1  one-cycle completion pulse
- aux_req, aux_we, aux_sz, aux_addr, aux_wdata, aux_rdata, aux_ready: same as the cpu_* ports, for requester 1
- err  out  1  one-cycle pulse on timeout abort, coincident with the owner's ready
- mem_req  out  1  request to memory
- mem_we, mem_sz, mem_addr, mem_wdata  out  1/1/ADDR_W/DATA_W  latched command
- mem_rdata  in  DATA_W  memory read data
- mem_ready  in  1  memory completion; sampled only while mem_req = 1

Behaviour:
- Reset values (asynchronous): state = ST_IDLE, last_grant = aux (so the CPU wins the first tie), all outputs 0, watchdog = 0.
- States:
  - ST_IDLE: sample requests.
    - Only one requester asserted: grant it.
    - Both asserted: grant the requester that is not last_grant.
    - On grant, in the same edge: latch we/sz/addr/wdata into the mem_* registers, set mem_req = 1, update last_grant, go to ST_BUSY_CPU or ST_BUSY_AUX.
  - ST_BUSY_x: mem_* outputs are frozen. Requester input changes are ignored.
    - Watchdog increments each cycle.
    - mem_ready = 1: register mem_rdata into x_rdata (reads only; writes leave x_rdata unchanged), pulse x_ready for 1 cycle, drop mem_req, clear the watchdog, go to ST_IDLE.
    - Watchdog reaches TIMEOUT without mem_ready: pulse x_ready and err, x_rdata = 0, drop mem_req, go to ST_IDLE.
- Latency:
  - Request asserted at edge N → mem_req high after edge N.
  - mem_ready sampled high at edge M → x_ready high in cycle M..M+1.
  - Earliest next mem_req is after edge M+1. There is always at least one idle cycle between transactions.
- Requester obligation: deassert req in the cycle x_ready is seen, or re-arm it intentionally. A req still high in ST_IDLE is treated as a new transaction.
- Ready is never given to the non-owner. cpu_ready and aux_ready are never high in the same cycle.
- mem_ready while in ST_IDLE is ignored.
- mem_ready in the same cycle the watchdog hits TIMEOUT: normal completion wins and err stays 0.
- Reset asserted mid-transaction: immediate return to the reset values. No ready pulse is issued and the transaction is lost.
- Fairness: under continuous dual requests, grants alternate CPU, AUX, CPU, and so on. Neither requester waits more than one transaction.

Decomposition:
- pkg_mem_arb (shared package): arb_state typedef enum {ST_IDLE, ST_BUSY_CPU, ST_BUSY_AUX}, requester-index constants (arb_req_cpu = 0, arb_req_aux = 1), and the default timeout constant.
- Access-size encoding is reused from pkg_cpu.
- One sub-module, rr_arbiter_2: combinational two-input round-robin pick, with last_grant as input and grant index plus valid as outputs. Keeps the priority logic separately testable.
- The watchdog counter stays inline.

Test Plan:
- Single CPU read: cpu_req = 1, addr = 16'h0010, sz = 16; memory answers 16'hBEEF after 3 cycles → mem_addr = 0010 and mem_req held 3 cycles, cpu_rdata = BEEF with cpu_ready pulsing 1 cycle, aux_ready stays 0.
- Simultaneous requests after reset: both req high, CPU reads 0x0000, AUX writes 16'h1234 to 0x8000 → CPU granted first, then AUX. mem_we = 1, mem_wdata = 1234 on the second transaction, with one idle cycle between.
- Sustained contention: both req re-armed for 6 transactions → grant order C, A, C, A, C, A; each ready goes only to its owner.
- Command stability: during ST_BUSY_CPU, change cpu_addr from 0x0010 to 0xFFFF → mem_addr stays 0x0010 until completion.
- Timeout: TIMEOUT = 4, mem_ready never asserted → after 4 busy cycles the owner's ready and err pulse together, rdata = 0, state returns to ST_IDLE, and the next request is accepted.
- Async reset mid-transaction: assert reset between edges while in ST_BUSY_AUX → mem_req = 0 immediately with no ready pulse; after release, the CPU wins the first tie.
